// File: rtl/uart_pkg.sv
// Shared serial-line definitions for the UART receiver and transmitter.
// Both ends import the same defaults so their bit timing always agrees.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 4;
    localparam int DEFAULT_W            = 8;
    localparam int HALF_BIT             = DEFAULT_CLKS_PER_BIT / 2;

    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// The reset value is a parameter so idle-high serial lines start out idle.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make both flops update from pre-edge values, giving a true 2-stage delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: mid-bit sampling of a synchronized line,
// LSB-first shift-in, stop-bit check, one-cycle valid / frame-error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int W            = DEFAULT_W
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_rxd,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_frame_err,
    output logic         o_busy,
    output logic         o_idle
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(W + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(W - 1);

    logic          rxd_s;
    uart_state_e   state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [W-1:0]  shreg, shreg_nx;
    logic          stop_ok, stop_ok_nx;
    logic          stop_bad, stop_bad_nx;
    logic [1:0]    warm;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .d     (i_rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nx;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + 1'b1;
        idx_nx      = idx;
        shreg_nx    = shreg;
        stop_ok_nx  = 1'b0;
        stop_bad_nx = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nx = '0;
                if (!rxd_s) begin
                    state_nx = START;
                    idx_nx   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nx   = '0;
                    state_nx = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx   = '0;
                    shreg_nx = {rxd_s, shreg[W-1:1]};
                    idx_nx   = idx + 1'b1;
                    if (idx == IDX_LAST) state_nx = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nx      = '0;
                    stop_ok_nx  = rxd_s;
                    stop_bad_nx = !rxd_s;
                    state_nx    = rxd_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // A held-low line stays here; only a return to idle re-arms the receiver.
                cnt_nx = '0;
                if (rxd_s) state_nx = IDLE;
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    // Strobes lag the stop sample by one stage so the word is registered before it is presented.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            stop_ok     <= 1'b0;
            stop_bad    <= 1'b0;
            warm        <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            shreg       <= shreg_nx;
            stop_ok     <= stop_ok_nx;
            stop_bad    <= stop_bad_nx;
            warm        <= {warm[0], 1'b1};
            o_valid     <= stop_ok;
            o_frame_err <= stop_bad;
            if (stop_ok) o_data <= shreg;
        end
    end

    assign o_busy = (state == START) || (state == DATA) || (state == STOP);
    assign o_idle = (state == IDLE) && rxd_s && warm[1];

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx (C=4, W=8): stimulus pushes expected words and
// strobe cycles; an independent monitor pops and compares on every strobe.
module tb_uart_rx;

    localparam int C = 4;
    // Start driven just after edge k -> first sampling edge F=k+1 -> strobe at F+41.
    localparam int LAT = 42;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       rxd;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;
    logic       idle;

    int   cyc;
    int   checks;
    int   failures;
    exp_t exp_q[$];
    int   err_q[$];

    uart_rx #(.CLKS_PER_BIT(C), .W(8)) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_rxd       (rxd),
        .o_data      (data),
        .o_valid     (valid),
        .o_frame_err (frame_err),
        .o_busy      (busy),
        .o_idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    // Called at posedge+2; drives start, 8 data bits LSB first, stop.
    task automatic send_frame(input logic [7:0] d, input logic stop, input bit expect_it);
        logic [9:0] bits;
        exp_t       e;
        bits = {stop, d, 1'b0};
        if (expect_it) begin
            if (stop) begin
                e.data = d;
                e.cyc  = cyc + LAT;
                exp_q.push_back(e);
            end else begin
                err_q.push_back(cyc + LAT);
            end
        end
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            repeat (C) @(posedge clk);
            #2;
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Monitor: every strobe must match the head of its queue, in value and cycle.
    always @(negedge clk) begin
        if (rst_n && (valid || frame_err)) begin
            check("valid_err_exclusive", {31'd0, valid & frame_err}, 32'd0);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'd0, valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("valid_data", {24'd0, data}, {24'd0, e.data});
                    check("valid_cycle", cyc, e.cyc);
                end
            end
            if (frame_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_frame_err", {31'd0, frame_err}, 32'd0);
                end else begin
                    int ec;
                    ec = err_q.pop_front();
                    check("frame_err_cycle", cyc, ec);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int bad;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        rxd      = 1'b1;

        // Reset state
        idle_cycles(3);
        check("reset_idle", {31'd0, idle}, 32'd0);
        check("reset_data", {24'd0, data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        base  = cyc;
        wait_edge(base + 3);
        check("idle_after_release", {31'd0, idle}, 32'd1);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (valid || frame_err || busy) bad++;
        end
        check("quiet_line_no_activity", bad, 32'd0);
        idle_cycles(1);

        // Frame 0xA5 with busy window: busy rises at F+2 and falls at F+40
        base = cyc;
        fork
            send_frame(8'hA5, 1'b1, 1'b1);
            begin
                wait_edge(base + 2);
                check("busy_before_E", {31'd0, busy}, 32'd0);
                wait_edge(base + 3);
                check("busy_at_E", {31'd0, busy}, 32'd1);
                wait_edge(base + 40);
                check("busy_before_stop_sample", {31'd0, busy}, 32'd1);
                wait_edge(base + 41);
                check("busy_after_stop_sample", {31'd0, busy}, 32'd0);
            end
        join
        idle_cycles(6);
        check("data_A5_held", {24'd0, data}, 32'hA5);

        // Back-to-back 0x00 then 0xFF, one stop bit each
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle_cycles(6);

        // One-cycle low glitch: false start, no pulses
        base = cyc;
        rxd  = 1'b0;
        idle_cycles(1);
        rxd  = 1'b1;
        wait_edge(base + 6);
        check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
        idle_cycles(10);
        check("glitch_data_unchanged", {24'd0, data}, 32'hFF);
        check("glitch_idle", {31'd0, idle}, 32'd1);

        // Frame 0x3C with low stop bit, line held low, then released
        send_frame(8'h3C, 1'b0, 1'b1);
        idle_cycles(60);
        check("break_not_idle", {31'd0, idle}, 32'd0);
        check("break_not_busy", {31'd0, busy}, 32'd0);
        check("break_data_unchanged", {24'd0, data}, 32'hFF);
        base = cyc;
        rxd  = 1'b1;
        wait_edge(base + 2);
        check("break_idle_early", {31'd0, idle}, 32'd0);
        wait_edge(base + 3);
        check("break_idle_returns", {31'd0, idle}, 32'd1);
        idle_cycles(4);
        send_frame(8'h5A, 1'b1, 1'b1);
        idle_cycles(6);

        // Reset during data bit 4 of 0x81, then a clean 0x42
        base = cyc;
        fork
            send_frame(8'h81, 1'b1, 1'b0);
            begin
                wait_edge(base + 22);
                rst_n = 1'b0;
                #1;
                check("midreset_data", {24'd0, data}, 32'd0);
                check("midreset_valid", {31'd0, valid}, 32'd0);
                check("midreset_err", {31'd0, frame_err}, 32'd0);
                check("midreset_busy", {31'd0, busy}, 32'd0);
                check("midreset_idle", {31'd0, idle}, 32'd0);
            end
        join
        rst_n = 1'b1;
        idle_cycles(5);
        send_frame(8'h42, 1'b1, 1'b1);
        idle_cycles(8);
        check("final_data_42", {24'd0, data}, 32'h42);

        check("valid_queue_drained", exp_q.size(), 32'd0);
        check("err_queue_drained", err_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
